// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
//
// Boot-load controller placed behind a UART receiver. It hunts for a sync
// byte, reads a 16-bit little-endian word count, assembles little-endian
// 32-bit words from the byte stream and writes them to instruction memory
// over a valid/ready port. The CPU core is held in reset until a load
// finishes successfully.
//
// Frame: SYNC, LEN_LO, LEN_HI, LEN*4 data bytes, [CSUM]
//
// Build option:
//   UART_LOADER_CHECKSUM_EN - when defined, a trailing CSUM byte (sum of all
//                             data bytes mod 256) is required and checked.
//                             When undefined, the load succeeds on the final
//                             write transfer (or right after LEN_HI if LEN==0).
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx_done      in   receiver done level; a rising edge marks a new byte
//   rx_byte      in   received byte, valid when rx_done rises
//   mem_wr_valid out  memory write request
//   mem_wr_ready in   memory write accepted
//   mem_addr     out  byte address of the current word (4-aligned)
//   mem_wdata    out  write data
//   busy         out  a frame is in progress
//   load_done    out  sticky success flag, cleared by the next sync byte
//   load_err     out  sticky abort flag, cleared by the next sync byte
//   cpu_rst_n    out  core reset, low until a load succeeds
// -----------------------------------------------------------------------------
module uart_loader #(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter logic [7:0]        SYNC_BYTE      = 8'hA5,
    parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_done,
    input  logic [7:0]        rx_byte,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_rst_n
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE
`ifdef UART_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_success;
    logic              w_abort;

    logic              r_rx_done_q;
    logic [15:0]       r_count;
    logic [1:0]        r_idx;
    logic [TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_cpu_rst_n;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_ev;
    logic              w_xfer;
    logic              w_tmo_hit;

    assign w_ev      = rx_done & ~r_rx_done_q;
    assign w_xfer    = r_valid & mem_wr_ready;
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and frame outcome
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_success    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ev && (rx_byte == SYNC_BYTE)) begin
                    w_state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_ev) begin
                    w_state_next = S_LEN_HI;
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (w_ev) begin
                    if ((rx_byte == 8'h00) && (r_count[7:0] == 8'h00)) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_success = 1'b1;
`endif
                    end else begin
                        w_state_next = S_DATA;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end
            S_DATA: begin
                if (w_ev) begin
                    if (r_idx == 2'd3) begin
                        w_state_next = S_WRITE;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end
            S_WRITE: begin
                // A byte arriving while a write is pending is an overrun.
                // A transfer completing in the same cycle still takes effect
                // in the datapath before the abort returns us to IDLE.
                if (w_ev) begin
                    w_abort = 1'b1;
                end else if (w_xfer) begin
                    if (r_count == 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        w_state_next = S_CHECK;
`else
                        w_success = 1'b1;
`endif
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_ev) begin
                    if (rx_byte == r_csum) begin
                        w_success = 1'b1;
                    end else begin
                        w_abort = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_success || w_abort) begin
            w_state_next = S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_done_q <= 1'b1;
            r_count     <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_rx_done_q <= rx_done;
            r_busy      <= (w_state_next != S_IDLE);

            // Inter-byte watchdog: restarts on every byte, frozen while a
            // write is pending so slow memory never trips it.
            if (w_ev || (w_state_next == S_IDLE)) begin
                r_tmo <= '0;
            end else if (r_state != S_WRITE) begin
                r_tmo <= r_tmo + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ev && (rx_byte == SYNC_BYTE)) begin
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_cpu_rst_n <= 1'b0;
                        r_addr      <= BASE_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
                        r_csum      <= '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (w_ev) begin
                        r_count[7:0] <= rx_byte;
                    end
                end
                S_LEN_HI: begin
                    if (w_ev) begin
                        r_count[15:8] <= rx_byte;
                        r_idx         <= '0;
                    end
                end
                S_DATA: begin
                    if (w_ev) begin
                        for (int i = 0; i < 4; i++) begin
                            if (r_idx == 2'(i)) begin
                                r_wdata[8*i +: 8] <= rx_byte;
                            end
                        end
                        r_idx <= r_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                        r_csum <= r_csum + rx_byte;
`endif
                        if (r_idx == 2'd3) begin
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        r_addr  <= r_addr + ADDR_W'(4);
                        r_count <= r_count - 16'd1;
                    end
                end
                default: begin
                end
            endcase

            if (w_success) begin
                r_done      <= 1'b1;
                r_cpu_rst_n <= 1'b1;
            end
            if (w_abort) begin
                r_err   <= 1'b1;
                r_valid <= 1'b0;
            end
        end
    end

    assign mem_wr_valid = r_valid;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign busy         = r_busy;
    assign load_done    = r_done;
    assign load_err     = r_err;
    assign cpu_rst_n    = r_cpu_rst_n;

endmodule

// File: tb/tb_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_loader
//
// Self-checking bench for uart_loader. Frames are built as byte queues; the
// expected memory image (word addresses, little-endian words) and checksum
// are derived from those queues and compared against the writes observed on
// the memory port and the status flags. Follows UART_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_uart_loader;

    localparam int          TMO  = 500;
    localparam logic [31:0] BASE = 32'h0;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        rx_done = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        load_done;
    logic        load_err;
    logic        cpu_rst_n;

    logic rand_ready  = 1'b0;
    logic ready_force = 1'b1;
    logic rnd_bit     = 1'b1;
    assign mem_wr_ready = rand_ready ? rnd_bit : ready_force;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  tx_data[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    uart_loader #(
        .ADDR_W         (32),
        .BASE_ADDR      (BASE),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_done      (rx_done),
        .rx_byte      (rx_byte),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .cpu_rst_n    (cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // Transfer monitor: a handshake seen mid-cycle completes on the next edge.
    always @(negedge clk) begin
        if (rst_n && mem_wr_valid && mem_wr_ready) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] csum_of();
        int s = 0;
        foreach (tx_data[i]) s += int'(tx_data[i]);
        return 8'(s % 256);
    endfunction

    task automatic build_expected();
        exp_addr.delete();
        exp_data.delete();
        for (int w = 0; w < tx_data.size() / 4; w++) begin
            exp_addr.push_back(BASE + 32'(4 * w));
            exp_data.push_back({tx_data[4*w+3], tx_data[4*w+2], tx_data[4*w+1], tx_data[4*w]});
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b0;
        rx_byte = b;
        tick(2);
        rx_done = 1'b1;
        tick(2);
    endtask

    task automatic wait_write_idle();
        int n = 0;
        while (mem_wr_valid === 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL write_stall: valid=%b after %0d cycles, required 0", mem_wr_valid, n);
        end
    endtask

    task automatic send_body(input logic [7:0] csum);
        int len = tx_data.size() / 4;
        send_byte(8'(len));
        send_byte(8'(len >> 8));
        foreach (tx_data[i]) begin
            send_byte(tx_data[i]);
            if (i % 4 == 3) wait_write_idle();
        end
        if (CSUM_ON) send_byte(csum);
        tick(2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        vectors++;
        if ({mem_wr_valid, mem_addr, mem_wdata, busy, load_done, load_err, cpu_rst_n} !==
            {1'b0, BASE, 32'h0, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_in: v=%b a=%h d=%h b/dn/er/cpu=%b%b%b%b, required all reset values",
                     mem_wr_valid, mem_addr, mem_wdata, busy, load_done, load_err, cpu_rst_n);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        vectors++;
        if ({mem_wr_valid, mem_addr, mem_wdata, busy, load_done, load_err, cpu_rst_n} !==
            {1'b0, BASE, 32'h0, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_out: v=%b a=%h d=%h b/dn/er/cpu=%b%b%b%b, required all reset values",
                     mem_wr_valid, mem_addr, mem_wdata, busy, load_done, load_err, cpu_rst_n);
        end
        $display("reset: checked");
    endtask

    task automatic test_basic();
        tx_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        build_expected();
        got_addr.delete();
        got_data.delete();
        send_byte(8'hA5);
        send_body(csum_of());
        vectors++;
        if (got_addr.size() != 2) begin
            miscompares++;
            $display("FAIL basic_count: got %0d writes, required 2", got_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                    miscompares++;
                    $display("FAIL basic_write%0d: got %h@%h, required %h@%h",
                             i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
                end
            end
        end
        vectors++;
        if ({load_done, load_err, cpu_rst_n, busy} !== 4'b1010) begin
            miscompares++;
            $display("FAIL basic_flags: done/err/cpu/busy=%b, required 1010",
                     {load_done, load_err, cpu_rst_n, busy});
        end
        $display("basic: csum=%h writes=%0d done=%b", csum_of(), got_addr.size(), load_done);
    endtask

`ifdef UART_LOADER_CHECKSUM_EN
    task automatic test_bad_csum();
        tx_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        build_expected();
        got_addr.delete();
        got_data.delete();
        send_byte(8'hA5);
        send_body(csum_of() + 8'd1);
        vectors++;
        if (got_addr.size() != 2) begin
            miscompares++;
            $display("FAIL badcsum_count: got %0d writes, required 2", got_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                    miscompares++;
                    $display("FAIL badcsum_write%0d: got %h@%h, required %h@%h",
                             i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
                end
            end
        end
        vectors++;
        if ({load_done, load_err, cpu_rst_n, busy} !== 4'b0100) begin
            miscompares++;
            $display("FAIL badcsum_flags: done/err/cpu/busy=%b, required 0100",
                     {load_done, load_err, cpu_rst_n, busy});
        end
        $display("bad_csum: sent=%h err=%b", csum_of() + 8'd1, load_err);
    endtask
`endif

    task automatic test_backpressure();
        tx_data.delete();
        for (int i = 0; i < 4; i++) tx_data.push_back(8'($urandom_range(0, 255)));
        build_expected();
        got_addr.delete();
        got_data.delete();
        ready_force = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        foreach (tx_data[i]) send_byte(tx_data[i]);
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if ({mem_wr_valid, mem_addr, mem_wdata} !== {1'b1, exp_addr[0], exp_data[0]}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: v=%b %h@%h, required 1 %h@%h",
                         c, mem_wr_valid, mem_wdata, mem_addr, exp_data[0], exp_addr[0]);
            end
            tick(1);
        end
        ready_force = 1'b1;
        wait_write_idle();
        tick(3);
        vectors++;
        if (got_addr.size() != 1) begin
            miscompares++;
            $display("FAIL bp_count: got %0d transfers, required 1", got_addr.size());
        end else begin
            vectors++;
            if ({got_addr[0], got_data[0]} !== {exp_addr[0], exp_data[0]}) begin
                miscompares++;
                $display("FAIL bp_write: got %h@%h, required %h@%h",
                         got_data[0], got_addr[0], exp_data[0], exp_addr[0]);
            end
        end
        if (CSUM_ON) send_byte(csum_of());
        tick(2);
        vectors++;
        if ({load_done, load_err, cpu_rst_n, busy} !== 4'b1010) begin
            miscompares++;
            $display("FAIL bp_flags: done/err/cpu/busy=%b, required 1010",
                     {load_done, load_err, cpu_rst_n, busy});
        end
        $display("backpressure: word=%h transfers=%0d", exp_data[0], got_addr.size());
    endtask

    task automatic test_timeout();
        int n = 0;
        send_byte(8'hA5);
        rx_done = 1'b0;
        rx_byte = 8'h01;
        tick(2);
        rx_done = 1'b1;
        @(posedge clk);  // edge that registers the LEN_LO byte event
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (busy !== 1'b1) break;
        end
        vectors++;
        if (n !== TMO) begin
            miscompares++;
            $display("FAIL timeout_cycles: busy fell after %0d clocks, required %0d", n, TMO);
        end
        vectors++;
        if ({busy, load_err, load_done, cpu_rst_n} !== 4'b0100) begin
            miscompares++;
            $display("FAIL timeout_flags: busy/err/done/cpu=%b, required 0100",
                     {busy, load_err, load_done, cpu_rst_n});
        end
        $display("timeout: abort after %0d clocks", n);
    endtask

    task automatic test_overrun();
        got_addr.delete();
        got_data.delete();
        ready_force = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i));
        send_byte(8'h5A);
        tick(1);
        vectors++;
        if ({busy, load_err, load_done, cpu_rst_n, mem_wr_valid} !== 5'b01000) begin
            miscompares++;
            $display("FAIL overrun_flags: busy/err/done/cpu/valid=%b, required 01000",
                     {busy, load_err, load_done, cpu_rst_n, mem_wr_valid});
        end
        ready_force = 1'b1;
        tick(3);
        vectors++;
        if (got_addr.size() != 0) begin
            miscompares++;
            $display("FAIL overrun_writes: got %0d transfers, required 0", got_addr.size());
        end
        $display("overrun: err=%b", load_err);
    endtask

    task automatic test_noise_reload();
        send_byte(8'h00);
        send_byte(8'hFF);
        vectors++;
        if ({busy, load_err} !== 2'b01) begin
            miscompares++;
            $display("FAIL noise_ignored: busy/err=%b, required 01", {busy, load_err});
        end
        for (int pass = 0; pass < 2; pass++) begin
            tx_data.delete();
            for (int i = 0; i < 12; i++) tx_data.push_back(8'($urandom_range(0, 255)));
            build_expected();
            got_addr.delete();
            got_data.delete();
            send_byte(8'hA5);
            vectors++;
            if ({busy, cpu_rst_n, load_err, load_done} !== 4'b1000) begin
                miscompares++;
                $display("FAIL reload%0d_sync: busy/cpu/err/done=%b, required 1000",
                         pass, {busy, cpu_rst_n, load_err, load_done});
            end
            send_body(csum_of());
            vectors++;
            if (got_addr.size() != 3) begin
                miscompares++;
                $display("FAIL reload%0d_count: got %0d writes, required 3", pass, got_addr.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    vectors++;
                    if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                        miscompares++;
                        $display("FAIL reload%0d_write%0d: got %h@%h, required %h@%h",
                                 pass, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
                    end
                end
            end
            vectors++;
            if ({load_done, load_err, cpu_rst_n, busy} !== 4'b1010) begin
                miscompares++;
                $display("FAIL reload%0d_flags: done/err/cpu/busy=%b, required 1010",
                         pass, {load_done, load_err, cpu_rst_n, busy});
            end
            $display("reload %0d: writes=%0d done=%b cpu_rst_n=%b", pass, got_addr.size(), load_done, cpu_rst_n);
        end
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int  len = $urandom_range(1, 4);
            bit  bad = CSUM_ON && ($urandom_range(0, 2) == 0);
            tx_data.delete();
            for (int i = 0; i < 4 * len; i++) tx_data.push_back(8'($urandom_range(0, 255)));
            build_expected();
            got_addr.delete();
            got_data.delete();
            send_byte(8'hA5);
            send_body(bad ? csum_of() ^ 8'h01 : csum_of());
            vectors++;
            if (got_addr.size() != len) begin
                miscompares++;
                $display("FAIL rand%0d_count: got %0d writes, required %0d", f, got_addr.size(), len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    vectors++;
                    if ({got_addr[i], got_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                        miscompares++;
                        $display("FAIL rand%0d_write%0d: got %h@%h, required %h@%h",
                                 f, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
                    end
                end
            end
            vectors++;
            if ({load_done, load_err, cpu_rst_n, busy} !== (bad ? 4'b0100 : 4'b1010)) begin
                miscompares++;
                $display("FAIL rand%0d_flags: done/err/cpu/busy=%b, required %b",
                         f, {load_done, load_err, cpu_rst_n, busy}, bad ? 4'b0100 : 4'b1010);
            end
            $display("random frame %0d: len=%0d bad_csum=%0b writes=%0d", f, len, bad, got_addr.size());
        end
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        got_addr.delete();
        got_data.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_wr_valid, mem_addr, mem_wdata, busy, load_done, load_err, cpu_rst_n} !==
            {1'b0, BASE, 32'h0, 4'b0000}) begin
            miscompares++;
            $display("FAIL midrst_async: v=%b a=%h d=%h b/dn/er/cpu=%b%b%b%b, required all reset values",
                     mem_wr_valid, mem_addr, mem_wdata, busy, load_done, load_err, cpu_rst_n);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send_byte(8'h04);
        tick(10);
        vectors++;
        if ({got_addr.size() == 0, mem_wr_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL midrst_nowrite: writes=%0d valid=%b busy=%b, required 0 0 0",
                     got_addr.size(), mem_wr_valid, busy);
        end
        $display("reset mid-frame: writes after release=%0d", got_addr.size());
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef UART_LOADER_CHECKSUM_EN
        test_bad_csum();
`endif
        test_backpressure();
        test_timeout();
        test_overrun();
        test_noise_reload();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-load controller that sits behind the UART receiver and turns its byte stream into memory writes. It hunts for a sync byte, reads a 16-bit word count, assembles little-endian 32-bit words, writes them to instruction memory through a valid/ready port and optionally verifies a checksum. The CPU core is held in reset until a load completes successfully.

## Interface
- `ADDR_W`, 32: memory address width.
- `BASE_ADDR`, 0: address of the first written word.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle clocks between bytes inside a frame. Must be ≥ 2.
- `clk` input, 1: system clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `rx_done` input, 1: receiver done level. It is high when idle, low during a byte and rises when the byte completes.
- `rx_byte` input, 8: received byte. Valid when `rx_done` rises.
- `mem_wr_valid` output, 1: write request.
- `mem_wr_ready` input, 1: write accepted. A transfer occurs on a cycle where valid and ready are both high.
- `mem_addr` output, ADDR_W: word address (byte addressing, 4-aligned).
- `mem_wdata` output, 32: write data.
- `busy` output, 1: a frame is in progress (any state except IDLE).
- `load_done` output, 1: sticky. Set when a load completes; cleared when the next sync byte is accepted.
- `load_err` output, 1: sticky. Set on abort; cleared when the next sync byte is accepted.
- `cpu_rst_n` output, 1: core reset. Low while no successful load exists.

## Operation
- Byte event: `ev = rx_done & ~rx_done_q`. `rx_done_q` resets to 1. `rx_byte` is sampled on the `ev` cycle.
- Frame format: SYNC, LEN_LO, LEN_HI, then LEN×4 data bytes (LSB first), then CSUM when the checksum feature is compiled in.
- States:
  - IDLE: on `ev` with byte == SYNC_BYTE, go to LEN_LO. On entry: clear `load_done`, `load_err` and the checksum; set `cpu_rst_n`=0; set `mem_addr`=BASE_ADDR. Any other byte is ignored.
  - LEN_LO → LEN_HI: on `ev`, latch count[7:0].
  - LEN_HI: on `ev`, latch count[15:8]. If count==0, go to CHECK (checksum on) or to IDLE with success (checksum off). Otherwise go to DATA with byte index 0.
  - DATA: on `ev`, shift the byte into `mem_wdata[8*idx +: 8]` and add it to the checksum (mod 256). The 4th byte goes to WRITE.
  - WRITE: hold `mem_wr_valid`=1 with address and data stable until ready. On the transfer, `mem_addr` += 4 and count -= 1. If the count becomes 0, go to CHECK/success; otherwise go to DATA.
  - CHECK: on `ev`, a byte equal to the checksum means success; anything else means abort.
- Success: return to IDLE; `load_done`=1; `cpu_rst_n`=1.
- Abort: return to IDLE; `load_err`=1; `cpu_rst_n` stays 0; `mem_wr_valid`=0.
- Abort triggers:
  - Timeout: counter reaches TIMEOUT_CYCLES-1 in LEN_LO, LEN_HI, DATA or CHECK. The counter clears on every `ev` and does not count in WRITE.
  - Overrun: `ev` occurs in WRITE. The byte is dropped; if the transfer completes on that same cycle, it still counts and the abort follows.
- Address arithmetic wraps modulo 2^ADDR_W. The count is 16 bits, so LEN=0xFFFF gives 65535 words.

## Timing
- Reset values: `mem_wr_valid`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `busy`=0, `load_done`=0, `load_err`=0, `cpu_rst_n`=0.
- Reset asserted mid-frame aborts immediately, with no further write issued.
- `mem_wr_valid` rises on the clock edge after the `ev` of the 4th data byte.
- `mem_wr_valid` falls on the edge after the transfer. There is never more than one write in flight.
- `busy`, `load_done`, `load_err` and `cpu_rst_n` update on the edge ending the deciding cycle (the sync `ev`, the final transfer, the CSUM `ev`, or the timeout/overrun cycle).
- All outputs are registered.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined:
  - The CHECK state exists and a CSUM byte is required.
  - CSUM = sum of all data bytes mod 256; the LEN bytes are excluded.
- Not defined:
  - There is no CHECK state and no checksum logic.
  - Success occurs on the final write transfer (or at LEN_HI when LEN==0).
  - The frame has no CSUM byte.

## Test plan
- Basic load, macro on: A5 02 00 11 22 33 44 55 66 77 88, then CSUM 0x64, with ready tied to 1.
  - Writes 0x44332211@0x0 and 0x88776655@0x4.
  - `load_done`=1 and `cpu_rst_n`=1.
- Bad checksum: same frame with CSUM 0x65.
  - Both writes occur.
  - `load_err`=1 and `cpu_rst_n` stays 0.
- Backpressure: `mem_wr_ready` held low for 10 cycles.
  - `mem_wr_valid`, `mem_addr` and `mem_wdata` stay stable for all 10 cycles.
  - Exactly one transfer occurs.
- Timeout: TIMEOUT_CYCLES=500, send A5 01 and then stop sending.
  - Abort 500 clocks after the last `ev`.
  - `busy`=0 and `load_err`=1.
- Noise and reload:
  - Bytes 00 FF before A5 are ignored.
  - A successful reload clears `load_err` and pulses `cpu_rst_n` low during the frame.
- Reset mid-frame: assert `rst_n` during DATA.
  - All outputs return to their reset values asynchronously.
  - No write occurs after reset is released.
